// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: rx synchroniser, bit-level FSM, small receive
// FIFO and a three-register bus responder (RXDATA, STATUS, CTRL).
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        ce,
  input  logic        memwrite,
  input  logic [3:0]  addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        valid,
  output logic        busy,
  output logic        intr_rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          rx_meta, rxs;
  logic          push, fe_set;

  logic [AW:0]   wptr, rptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          empty, full, rd, wr, pop, do_push, ovr_set;
  logic          frame_err, overrun, rx_ie;
  logic [1:0]    sel;
  logic          unused;

  assign unused = ^{addr[1:0], datain[31:4], datain[1]};
  assign busy   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // push/fe_set are one-cycle pulses, applied to the FIFO and flags on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      push   <= 1'b0;
      fe_set <= 1'b0;
    end else begin
      push   <= 1'b0;
      fe_set <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shift[idx] <= rxs;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxs) begin
              push  <= 1'b1;
              state <= IDLE;
            end else begin
              fe_set <= 1'b1;
              state  <= WAIT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel     = addr[3:2];
  assign rd      = ce & ~memwrite;
  assign wr      = ce & memwrite;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop     = rd && (sel == 2'd0) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign intr_rx = rx_ie & (~empty | frame_err | overrun);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_ie     <= 1'b0;
      dataout   <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= ce;
      if (pop)     rptr <= rptr + (AW+1)'(1);
      if (do_push) wptr <= wptr + (AW+1)'(1);
      frame_err <= fe_set  | (frame_err & ~(wr && sel == 2'd1 && datain[2]));
      overrun   <= ovr_set | (overrun   & ~(wr && sel == 2'd1 && datain[3]));
      if (wr && sel == 2'd2) rx_ie <= datain[0];
      if (rd) begin
        case (sel)
          2'd0:    dataout <= empty ? 32'h100 : {24'b0, mem[rptr[AW-1:0]]};
          2'd1:    dataout <= {28'b0, overrun, frame_err, full, ~empty};
          2'd2:    dataout <= {31'b0, rx_ie};
          default: dataout <= '0;
        endcase
      end
    end
  end
endmodule
